tow_autoplayer: RTL

Automated opponent for the tug-of-war game: sits on the far side of the game's button/LED interface, watches `leds_out`, and drives `pbl`/`pbr` like two human players. Each side has its own pseudo-random reaction delay. Optional per-side "jump" (early press) and a press timeout are provided. Used for attract/demo mode on the board and as the stimulus engine for in-system soak tests of the game core.

---
 rtl/tow_pkg.sv | 38 +++
 rtl/tow_autoplayer_if.sv | 36 +++
 rtl/tow_lfsr16.sv | 36 +++
 rtl/tow_autoplayer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war game core, the autoplayer and benches.
//   - 7-bit display codes driven on leds_out by the game core
//   - autoplayer FSM state encoding
//   - one step of the 16-bit Galois LFSR (mask 16'hB400, right-shifting)
// -----------------------------------------------------------------------------
package tow_pkg;

    localparam logic [6:0] DARK   = 7'h00;
    localparam logic [6:0] GO     = 7'h7F;
    localparam logic [6:0] LWIN   = 7'h70;
    localparam logic [6:0] RWIN   = 7'h07;
    localparam logic [6:0] SPLASH = 7'h4D;
    localparam logic [6:0] CENTER = 7'h08;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DARK = 3'd1,
        ST_WAIT_GO   = 3'd2,
        ST_REACT     = 3'd3,
        ST_PRESS     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Galois form: shift right, fold the bit shifted out back in via the mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tow_autoplayer_if.sv
// -----------------------------------------------------------------------------
// tow_autoplayer_if
// Button/LED side of the autoplayer.
//   en         autoplayer enable (low forces idle)
//   leds_out   7-bit game display, as driven by the game core
//   jump_l/r   per-side early press during the dark phase
//   pbl/pbr    left/right push-button drive
//   busy       high in any state except IDLE/DONE
//   round_cnt  completed rounds, saturating at 255
//   err        sticky press-timeout flag
// master: the side that drives display/controls (game core or bench)
// slave : the autoplayer itself
// -----------------------------------------------------------------------------
interface tow_autoplayer_if;

    logic       en;
    logic [6:0] leds_out;
    logic       jump_l;
    logic       jump_r;
    logic       pbl;
    logic       pbr;
    logic       busy;
    logic [7:0] round_cnt;
    logic       err;

    modport master (
        output en, leds_out, jump_l, jump_r,
        input  pbl, pbr, busy, round_cnt, err
    );

    modport slave (
        input  en, leds_out, jump_l, jump_r,
        output pbl, pbr, busy, round_cnt, err
    );

endinterface

// File: rtl/tow_lfsr16.sv
// -----------------------------------------------------------------------------
// tow_lfsr16
// 16-bit Galois LFSR used for the per-side reaction delays.
//   clk   system clock, rising edge
//   rst   synchronous, active-low reset; loads seed
//   en    advance one step per cycle while high, hold otherwise
//   seed  reset value; an all-zero seed is replaced by 16'h0001
//   q     current LFSR state
// -----------------------------------------------------------------------------
module tow_lfsr16
    import tow_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic [15:0] w_seed;

    // all-zero is the lock-up state of the register
    assign w_seed = (seed == '0) ? 16'h0001 : seed;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= w_seed;
        end else if (en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tow_autoplayer.sv
// -----------------------------------------------------------------------------
// tow_autoplayer
// Automated opponent for the tug-of-war game. Watches the display and drives
// both push-buttons with independent pseudo-random reaction delays, optional
// per-side jump (press during dark phase) and a press-hold timeout.
//   clk   system clock, rising edge
//   rst   synchronous, active-low reset
//   bus   tow_autoplayer_if.slave (en, leds_out, jump_l/r in;
//         pbl, pbr, busy, round_cnt, err out; all outputs registered)
// -----------------------------------------------------------------------------
module tow_autoplayer
    import tow_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned BASE_DLY  = 8,
    parameter int unsigned CW        = 10,
    parameter int unsigned HOLD_MAX  = 255
) (
    input  logic          clk,
    input  logic          rst,
    tow_autoplayer_if.slave bus
);

    localparam int unsigned HW = $clog2(HOLD_MAX + 1);

    state_t        r_state;
    logic          r_pbl;
    logic          r_pbr;
    logic          r_busy;
    logic          r_err;
    logic [7:0]    r_round;
    logic          r_jump;      // current press was a jump (no reaction counting)
    logic [CW-1:0] r_dl;
    logic [CW-1:0] r_dr;
    logic [HW-1:0] r_hold;

    logic [15:0]   w_lfsr;
    logic [CW-1:0] w_dl_load;
    logic [CW-1:0] w_dr_load;
    logic          w_fire_l;
    logic          w_fire_r;
    logic          w_release;
    logic          w_win;
    logic          w_timeout;
    logic          w_jump_any;

    tow_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    assign w_dl_load  = CW'(BASE_DLY) + CW'(w_lfsr[3:0]);
    assign w_dr_load  = CW'(BASE_DLY) + CW'(w_lfsr[7:4]);

    // a side fires on the cycle its counter is seen at zero
    assign w_fire_l   = (r_dl == '0) && !r_pbl;
    assign w_fire_r   = (r_dr == '0) && !r_pbr;

    // a jump press is released by any non-dark display; a normal press also
    // has to see the display leave GO
    assign w_release  = r_jump ? (bus.leds_out != DARK)
                               : ((bus.leds_out != DARK) && (bus.leds_out != GO));
    assign w_win      = (bus.leds_out == LWIN) || (bus.leds_out == RWIN);
    assign w_timeout  = (r_hold == HW'(HOLD_MAX - 1));
    assign w_jump_any = bus.jump_l || bus.jump_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pbl   <= 1'b0;
            r_pbr   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_round <= '0;
            r_jump  <= 1'b0;
            r_dl    <= '0;
            r_dr    <= '0;
            r_hold  <= '0;
        end else if (!bus.en) begin
            // counters, err and round count are left untouched
            r_state <= ST_IDLE;
            r_pbl   <= 1'b0;
            r_pbr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT_DARK;
                    r_busy  <= 1'b1;
                end

                ST_WAIT_DARK: begin
                    if (bus.leds_out == DARK) begin
                        r_state <= ST_WAIT_GO;
                    end
                end

                ST_WAIT_GO: begin
                    // jump wins over a GO sampled in the same cycle
                    if (w_jump_any) begin
                        r_pbl   <= bus.jump_l;
                        r_pbr   <= bus.jump_r;
                        r_jump  <= 1'b1;
                        r_hold  <= '0;
                        r_state <= ST_PRESS;
                    end else if (bus.leds_out == GO) begin
                        r_dl    <= w_dl_load;
                        r_dr    <= w_dr_load;
                        r_jump  <= 1'b0;
                        r_state <= ST_REACT;
                    end
                end

                ST_REACT: begin
                    if (r_dl != '0) r_dl <= r_dl - 1'b1;
                    if (r_dr != '0) r_dr <= r_dr - 1'b1;
                    if (w_fire_l) r_pbl <= 1'b1;
                    if (w_fire_r) r_pbr <= 1'b1;
                    if (w_fire_l || w_fire_r) begin
                        r_hold  <= '0;
                        r_state <= ST_PRESS;
                    end
                end

                ST_PRESS: begin
                    if (w_release) begin
                        r_pbl   <= 1'b0;
                        r_pbr   <= 1'b0;
                        if (r_round != 8'hFF) r_round <= r_round + 8'd1;
                        r_state <= w_win ? ST_DONE : ST_WAIT_DARK;
                        r_busy  <= !w_win;
                    end else if (w_timeout) begin
                        r_pbl   <= 1'b0;
                        r_pbr   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_WAIT_DARK;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                        // the slower side keeps reacting after the first press
                        if (!r_jump) begin
                            if (r_dl != '0) r_dl <= r_dl - 1'b1;
                            if (r_dr != '0) r_dr <= r_dr - 1'b1;
                            if (w_fire_l) r_pbl <= 1'b1;
                            if (w_fire_r) r_pbr <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    if (bus.leds_out == SPLASH) begin
                        r_state <= ST_WAIT_DARK;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_pbl   <= 1'b0;
                    r_pbr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pbl       = r_pbl;
    assign bus.pbr       = r_pbr;
    assign bus.busy      = r_busy;
    assign bus.round_cnt = r_round;
    assign bus.err       = r_err;

endmodule
